// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM master.
// Latches one request, holds strobes until completion or timeout.
module sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_rd_req,
  input  logic        p1_rd_req,
  input  logic        p0_wr_req,
  input  logic        p1_wr_req,
  input  logic [31:0] p0_address,
  input  logic [31:0] p1_address,
  input  logic [31:0] p0_write_data,
  input  logic [31:0] p1_write_data,
  output logic [31:0] p0_read_data,
  output logic [31:0] p1_read_data,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] sdram_address,
  output logic        rd_en,
  output logic        wr_en,
  output logic [31:0] write_data_input,
  input  logic [31:0] read_data,
  input  logic        write_complete,
  input  logic        read_complete,
  output logic        timeout_err
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rd0_q, rd0_d;
  logic [31:0]   rd1_q, rd1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          terr_q, terr_d;

  logic req0, req1, pick, cpl;

  assign req0 = p0_rd_req | p0_wr_req;
  assign req1 = p1_rd_req | p1_wr_req;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    terr_d  = terr_q;
    // lone requester wins; on a tie the port not served last wins
    pick    = (req0 & req1) ? ~last_q : req1;
    cpl     = wr_q ? write_complete : read_complete;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          port_d  = pick;
          wr_d    = pick ? p1_wr_req : p0_wr_req;
          addr_d  = pick ? p1_address : p0_address;
          wdata_d = pick ? p1_write_data : p0_write_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cpl || cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          last_d  = port_q;
          done0_d = ~port_q;
          done1_d = port_q;
          if (cpl && !wr_q) begin
            if (port_q) rd1_d = read_data;
            else        rd0_d = read_data;
          end
          if (!cpl) terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      terr_q  <= terr_d;
    end
  end

  logic busy;
  assign busy = (state_q == BUSY);

  assign rd_en            = busy & ~wr_q;
  assign wr_en            = busy & wr_q;
  assign sdram_address    = busy ? addr_q : '0;
  assign write_data_input = busy ? wdata_q : '0;
  assign p0_read_data     = rd0_q;
  assign p1_read_data     = rd1_q;
  assign p0_done          = done0_q;
  assign p1_done          = done1_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: scenario tasks plus a done-pulse
// scoreboard checking per-port read data.
module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p0_rd_req = 0, p1_rd_req = 0;
  logic        p0_wr_req = 0, p1_wr_req = 0;
  logic [31:0] p0_address = 0, p1_address = 0;
  logic [31:0] p0_write_data = 0, p1_write_data = 0;
  logic [31:0] p0_read_data, p1_read_data;
  logic        p0_done, p1_done;
  logic [31:0] sdram_address;
  logic        rd_en, wr_en;
  logic [31:0] write_data_input;
  logic [31:0] read_data = 0;
  logic        write_complete = 0, read_complete = 0;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd0 = 0;
  logic [31:0] exp_rd1 = 0;

  sdram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset(reset),
    .p0_rd_req(p0_rd_req),
    .p1_rd_req(p1_rd_req),
    .p0_wr_req(p0_wr_req),
    .p1_wr_req(p1_wr_req),
    .p0_address(p0_address),
    .p1_address(p1_address),
    .p0_write_data(p0_write_data),
    .p1_write_data(p1_write_data),
    .p0_read_data(p0_read_data),
    .p1_read_data(p1_read_data),
    .p0_done(p0_done),
    .p1_done(p1_done),
    .sdram_address(sdram_address),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .write_data_input(write_data_input),
    .read_data(read_data),
    .write_complete(write_complete),
    .read_complete(read_complete),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Scoreboard: each done pulse pops one expected result.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      checks++;
      if (rd_en === 1'b1 && wr_en === 1'b1) begin
        errors++;
        $display("FAIL strobe_excl: rd_en=1 wr_en=1 required not both");
      end
      if (p0_done === 1'b1 || p1_done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: p0_done=%b p1_done=%b none pending",
                   p0_done, p1_done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if ({p1_done, p0_done} !== (e.port ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL done_port: p1/p0_done=%b%b required port %0d",
                     p1_done, p0_done, e.port);
          end
          checks++;
          if (e.port == 1'b0) begin
            if (p0_read_data !== e.data || p1_read_data !== exp_rd1) begin
              errors++;
              $display("FAIL rdata_p0: p0=%h p1=%h required p0=%h p1=%h",
                       p0_read_data, p1_read_data, e.data, exp_rd1);
            end
            exp_rd0 = e.data;
          end else begin
            if (p1_read_data !== e.data || p0_read_data !== exp_rd0) begin
              errors++;
              $display("FAIL rdata_p1: p1=%h p0=%h required p1=%h p0=%h",
                       p1_read_data, p0_read_data, e.data, exp_rd0);
            end
            exp_rd1 = e.data;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    {p0_rd_req, p1_rd_req, p0_wr_req, p1_wr_req} = '0;
    {write_complete, read_complete} = '0;
    sb.delete();
    exp_rd0 = 0;
    exp_rd1 = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rd_en, wr_en, sdram_address, write_data_input, p0_read_data,
         p1_read_data, p0_done, p1_done, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outs: rd=%b wr=%b addr=%h wd=%h r0=%h r1=%h d=%b%b te=%b required all 0",
               rd_en, wr_en, sdram_address, write_data_input, p0_read_data,
               p1_read_data, p0_done, p1_done, timeout_err);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int n_wr = 0;
    p0_wr_req = 1;
    p0_address = 32'h10;
    p0_write_data = 32'hA5A5A5A5;
    sb.push_back('{1'b0, exp_rd0});
    tick();
    for (int c = 0; c < 3; c++) begin
      if (wr_en === 1'b1 && rd_en === 1'b0 && sdram_address === 32'h10 &&
          write_data_input === 32'hA5A5A5A5)
        n_wr++;
      if (c == 1) read_complete = 1;
      if (c == 2) begin
        read_complete = 0;
        write_complete = 1;
      end
      tick();
    end
    checks++;
    if (n_wr != 3) begin
      errors++;
      $display("FAIL wr_cycles: got %0d required 3", n_wr);
    end
    checks++;
    if (wr_en !== 1'b0 || p0_done !== 1'b1 || sdram_address !== 0) begin
      errors++;
      $display("FAIL wr_release: wr_en=%b p0_done=%b addr=%h required 0/1/0",
               wr_en, p0_done, sdram_address);
    end
    write_complete = 0;
    p0_wr_req = 0;
    tick();
    checks++;
    if (p0_done !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: p0_done=%b wr_en=%b rd_en=%b required 0",
               p0_done, wr_en, rd_en);
    end
  endtask

  task automatic test_tie_after_p0();
    p0_rd_req = 1;
    p1_rd_req = 1;
    p0_address = 32'h500;
    p1_address = 32'h600;
    tick();
    checks++;
    if (rd_en !== 1'b1 || sdram_address !== 32'h600) begin
      errors++;
      $display("FAIL tie_p1: rd_en=%b addr=%h required 1/00000600",
               rd_en, sdram_address);
    end
    read_data = 32'h66;
    read_complete = 1;
    sb.push_back('{1'b1, 32'h66});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p1_rd_req = 0;
    tick();
    tick();
    checks++;
    if (rd_en !== 1'b1 || sdram_address !== 32'h500) begin
      errors++;
      $display("FAIL tie_p0_next: rd_en=%b addr=%h required 1/00000500",
               rd_en, sdram_address);
    end
    read_data = 32'h55;
    read_complete = 1;
    sb.push_back('{1'b0, 32'h55});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p0_rd_req = 0;
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    reset = 1'b1;
    tick();
    p0_rd_req = 1;
    p1_rd_req = 1;
    p0_address = 32'h100;
    p1_address = 32'h200;
    tick();
    checks++;
    if (rd_en !== 1'b1 || sdram_address !== 32'h100) begin
      errors++;
      $display("FAIL rr_first: rd_en=%b addr=%h required 1/00000100",
               rd_en, sdram_address);
    end
    read_data = 32'h11;
    read_complete = 1;
    sb.push_back('{1'b0, 32'h11});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p0_rd_req = 0;
    tick();
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: rd_en=%b wr_en=%b required 0", rd_en, wr_en);
    end
    tick();
    checks++;
    if (rd_en !== 1'b1 || sdram_address !== 32'h200) begin
      errors++;
      $display("FAIL rr_second: rd_en=%b addr=%h required 1/00000200",
               rd_en, sdram_address);
    end
    read_data = 32'h22;
    read_complete = 1;
    sb.push_back('{1'b1, 32'h22});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p1_rd_req = 0;
    tick();
  endtask

  task automatic test_write_priority();
    p1_rd_req = 1;
    p1_wr_req = 1;
    p1_address = 32'h300;
    p1_write_data = 32'hCAFEBABE;
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_en !== 1'b0 ||
        write_data_input !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL prio_wr: wr_en=%b rd_en=%b wd=%h required 1/0/cafebabe",
               wr_en, rd_en, write_data_input);
    end
    read_complete = 1;
    tick();
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL prio_ignore_rc: wr_en=%b required 1", wr_en);
    end
    read_complete = 0;
    write_complete = 1;
    sb.push_back('{1'b1, exp_rd1});
    tick();
    write_complete = 0;
    p1_wr_req = 0;
    tick();
    tick();
    checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || sdram_address !== 32'h300) begin
      errors++;
      $display("FAIL prio_rd: rd_en=%b wr_en=%b addr=%h required 1/0/00000300",
               rd_en, wr_en, sdram_address);
    end
    read_data = 32'h33;
    read_complete = 1;
    sb.push_back('{1'b1, 32'h33});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p1_rd_req = 0;
    tick();
  endtask

  task automatic test_complete_at_timeout();
    p1_rd_req = 1;
    p1_address = 32'h900;
    tick();
    for (int c = 1; c < 8; c++) tick();
    checks++;
    if (rd_en !== 1'b1) begin
      errors++;
      $display("FAIL edge_busy8: rd_en=%b required 1", rd_en);
    end
    read_data = 32'h77;
    read_complete = 1;
    sb.push_back('{1'b1, 32'h77});
    tick();
    checks++;
    if (p1_done !== 1'b1 || timeout_err !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL edge_cpl: p1_done=%b timeout_err=%b rd_en=%b required 1/0/0",
               p1_done, timeout_err, rd_en);
    end
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p1_rd_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n_busy = 0;
    p0_rd_req = 1;
    p0_address = 32'h400;
    read_data = 32'h12345678;
    sb.push_back('{1'b0, exp_rd0});
    tick();
    while (rd_en === 1'b1 && n_busy < 20) begin
      n_busy++;
      tick();
    end
    checks++;
    if (n_busy != 8) begin
      errors++;
      $display("FAIL to_cycles: got %0d BUSY cycles required 8", n_busy);
    end
    checks++;
    if (p0_done !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_abort: p0_done=%b timeout_err=%b required 1/1",
               p0_done, timeout_err);
    end
    p0_rd_req = 0;
    tick();
    tick();
    tick();
    checks++;
    if (timeout_err !== 1'b1 || p0_done !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky: timeout_err=%b p0_done=%b required 1/0",
               timeout_err, p0_done);
    end
  endtask

  task automatic test_reset_in_busy();
    p1_wr_req = 1;
    p1_address = 32'hA00;
    p1_write_data = 32'h5A5A5A5A;
    tick();
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy: wr_en=%b required 1", wr_en);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0 || sdram_address !== 0 ||
        p1_done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rb_async: wr=%b rd=%b addr=%h p1_done=%b te=%b required 0",
               wr_en, rd_en, sdram_address, p1_done, timeout_err);
    end
    exp_rd0 = 0;
    exp_rd1 = 0;
    p1_wr_req = 0;
    p0_rd_req = 1;
    p1_rd_req = 1;
    p0_address = 32'h700;
    p1_address = 32'h800;
    tick();
    #2;
    reset = 1'b1;
    tick();
    checks++;
    if (rd_en !== 1'b1 || sdram_address !== 32'h700) begin
      errors++;
      $display("FAIL rb_tie: rd_en=%b addr=%h required 1/00000700",
               rd_en, sdram_address);
    end
    read_data = 32'h99;
    read_complete = 1;
    sb.push_back('{1'b0, 32'h99});
    tick();
    read_complete = 0;
    read_data = 32'hDEADBEEF;
    p0_rd_req = 0;
    p1_rd_req = 0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_tie_after_p0();
    test_round_robin();
    test_write_priority();
    test_complete_at_timeout();
    test_timeout();
    test_reset_in_busy();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum BUSY cycles before a transfer is aborted.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset; asserted when 0.
REQ-004 The block SHALL have ports p0_rd_req and p1_rd_req, input, 1, read request per requester.
REQ-005 The block SHALL have ports p0_wr_req and p1_wr_req, input, 1, write request per requester.
REQ-006 The block SHALL have ports p0_address and p1_address, input, 32, byte address per requester.
REQ-007 The block SHALL have ports p0_write_data and p1_write_data, input, 32, write data per requester.
REQ-008 The block SHALL have ports p0_read_data and p1_read_data, output, 32, last read result per requester.
REQ-009 The block SHALL have ports p0_done and p1_done, output, 1, one-cycle completion pulse per requester.
REQ-010 The block SHALL have port sdram_address, output, 32, address to the SDRAM master.
REQ-011 The block SHALL have ports rd_en and wr_en, output, 1 each, operation strobes to the SDRAM master.
REQ-012 The block SHALL have port write_data_input, output, 32, write data to the SDRAM master.
REQ-013 The block SHALL have port read_data, input, 32, read result from the SDRAM master.
REQ-014 The block SHALL have ports write_complete and read_complete, input, 1 each, completion flags from the SDRAM master.
REQ-015 The block SHALL have port timeout_err, output, 1, sticky flag set on any aborted transfer.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RELEASE.
REQ-017 In IDLE with any request, the block SHALL grant round-robin: port other than last_grant wins when both request; a lone requester wins regardless.
REQ-018 On grant, the block SHALL latch port id, op, address and write data, clear the timeout counter and enter BUSY.
REQ-019 If a granted port asserts both rd_req and wr_req, write SHALL win; the read stays pending.
REQ-020 In BUSY, sdram_address, write_data_input and exactly one of rd_en/wr_en SHALL be driven from the latched registers, stable every cycle.
REQ-021 Outside BUSY, rd_en, wr_en, sdram_address and write_data_input SHALL be 0.
REQ-022 Latency: request sampled in IDLE at edge N -> strobe high from cycle N+1.
REQ-023 Only the complete flag matching the latched op SHALL end BUSY; the other flag is ignored.
REQ-024 Completion sampled at edge M -> next cycle: RELEASE, strobes low, granted pN_done high one cycle, and for reads pN_read_data = read_data sampled at M.
REQ-025 last_grant SHALL update to the granted port on completion or abort.
REQ-026 RELEASE SHALL last exactly one cycle, ignore all requests, then return to IDLE; requesters drop req in their done cycle.
REQ-027 The timeout counter SHALL increment each BUSY cycle; reaching TIMEOUT_CYCLES-1 without completion SHALL abort to RELEASE, pulse pN_done, leave pN_read_data unchanged and set timeout_err.
REQ-028 Completion and timeout in the same cycle SHALL be treated as completion; timeout_err unchanged.
REQ-029 The ungranted port's read_data and done SHALL never change during another port's transfer.

Reset
REQ-030 While reset=0: state IDLE, last_grant=1 (port 0 wins first tie), counter 0, all outputs 0 including timeout_err.
REQ-031 Reset asserted mid-BUSY SHALL drop strobes immediately (asynchronous) with no done pulse.
REQ-032 timeout_err SHALL clear only on reset.

Verification
REQ-033 p0 write addr 0x10 data 0xA5A5A5A5, write_complete 3 cycles later -> wr_en high 3 cycles, p0_done 1 cycle, then 1 idle cycle.
REQ-034 p0 and p1 read simultaneously after reset -> p0 served first, p1 next; read_data 0x11/0x22 appear on p0_read_data/p1_read_data only.
REQ-035 p1 holds rd_req and wr_req -> write first, then read; wr_en and rd_en never high together.
REQ-036 TIMEOUT_CYCLES=8, no completion -> abort after 8 BUSY cycles, p0_done pulses, timeout_err stays 1.
REQ-037 Reset pulled low in BUSY -> rd_en/wr_en 0 same cycle, no done; after release port 0 wins first tie.
